stream_fifo: RTL

Synchronous first-word-fall-through FIFO that buffers a WIDTH-bit data stream between a producer port (clk, data) and a downstream consumer, decoupling their flow control with valid/ready handshakes on both sides. It sits directly downstream of the parameterised data-source modules (WIDTH/DEPTH style) and absorbs their bursts. Occupancy and an almost-full flag are exported for upstream throttling.

---
 rtl/stream_fifo.sv | 68 ++++++
 1 files changed

// File: rtl/stream_fifo.sv
// rtl/stream_fifo.sv - first-word-fall-through stream FIFO with occupancy, almost-full and sticky overflow
module stream_fifo #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = DEPTH - 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     almost_full,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
    localparam logic [CW-1:0] AF_COUNT   = CW'(AF_LEVEL);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             wr_fire;
    logic             rd_fire;

    // Full and empty come from count alone; pointers are free-running and wrap naturally.
    // A full FIFO refuses writes even when a read fires in the same cycle.
    assign in_ready    = (count != FULL_COUNT) && !rst;
    assign out_valid   = (count != '0);
    assign out_data    = out_valid ? mem[rd_ptr] : '0;
    assign almost_full = (count >= AF_COUNT);
    assign wr_fire     = in_valid && in_ready;
    assign rd_fire     = out_valid && out_ready;

    // Storage is not reset; only writes that actually fire touch it.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[wr_ptr] <= in_data;
        end
    end

    // Pointer, occupancy and sticky overflow state; reset discards queued data and same-cycle fires.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_fire) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_fire) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(wr_fire) - CW'(rd_fire);
            if (in_valid && !in_ready) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule
